egd_stream_ctrl: RTL and testbench

//  Sequencer in front of the exp-Golomb decoder (egd_top). Takes 16-bit bitstream words

---
 rtl/egd_pkg.sv | 33 +++
 rtl/egd_bit_buffer.sv | 65 ++++++
 rtl/egd_stream_ctrl.sv | 177 +++++++++++++++++
 tb/tb_egd_stream_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/egd_pkg.sv
// ---------------------------------------------------------------------------
// egd_pkg
//   Shared types and constants for the exp-Golomb stream controller slice.
//   - egd_state_e : sequencer states
//   - SEL_*       : element-type codes carried on cmd_sel_i / dec_sel_o
//   - DEF_*       : default widths used by the controller and bit buffer
// ---------------------------------------------------------------------------
package egd_pkg;

    localparam int DEF_WORD_W = 16;
    localparam int DEF_BUF_W  = 32;
    localparam int DEF_VAL_W  = 8;
    localparam int DEF_LEN_W  = 5;
    localparam int DEF_CNT_W  = 8;
    // fill count spans 0..BUF_W inclusive, so one bit wider than log2(BUF_W)
    localparam int FILL_W     = 6;

    localparam logic [1:0] SEL_UE   = 2'b00;
    localparam logic [1:0] SEL_SE   = 2'b01;
    localparam logic [1:0] SEL_TE   = 2'b10;
    localparam logic [1:0] SEL_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BITS = 3'd1,
        START     = 3'd2,
        WAIT_DEC  = 3'd3,
        CONSUME   = 3'd4,
        EMIT      = 3'd5,
        ERR       = 3'd6
    } egd_state_e;

endpackage

// File: rtl/egd_bit_buffer.sv
// ---------------------------------------------------------------------------
// egd_bit_buffer
//   MSB-aligned bit buffer feeding the decoder window. New words are appended
//   directly below the currently valid bits; consumed bits are shifted out of
//   the top with zeros filling from the bottom.
// Ports
//   clk, reset_n    clock, synchronous active-low reset
//   load_i          append load_word_i below the valid bits (fill += WORD_W)
//   load_word_i     word to append, first bit at MSB
//   consume_i       drop consume_len_i bits from the top
//   consume_len_i   number of bits to drop
//   window_o        top WORD_W bits of the buffer
//   fill_o          number of valid bits, 0..BUF_W
// ---------------------------------------------------------------------------
module egd_bit_buffer
    import egd_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int BUF_W  = DEF_BUF_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [WORD_W-1:0] load_word_i,
    input  logic              consume_i,
    input  logic [LEN_W-1:0]  consume_len_i,
    output logic [WORD_W-1:0] window_o,
    output logic [FILL_W-1:0] fill_o
);

    logic [BUF_W-1:0]  bits_q, bits_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [BUF_W-1:0]  load_ext;
    logic [BUF_W-1:0]  load_mask;

    always_comb begin
        load_ext  = {load_word_i, {(BUF_W-WORD_W){1'b0}}} >> fill_q;
        load_mask = {{WORD_W{1'b1}}, {(BUF_W-WORD_W){1'b0}}} >> fill_q;
        bits_d    = bits_q;
        fill_d    = fill_q;
        // The controller never asserts both; load wins only as a safe default.
        if (load_i) begin
            bits_d = (bits_q & ~load_mask) | load_ext;
            fill_d = fill_q + FILL_W'(WORD_W);
        end else if (consume_i) begin
            bits_d = bits_q << consume_len_i;
            fill_d = fill_q - FILL_W'(consume_len_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bits_q <= '0;
            fill_q <= '0;
        end else begin
            bits_q <= bits_d;
            fill_q <= fill_d;
        end
    end

    assign window_o = bits_q[BUF_W-1 -: WORD_W];
    assign fill_o   = fill_q;

endmodule

// File: rtl/egd_stream_ctrl.sv
// ---------------------------------------------------------------------------
// egd_stream_ctrl
//   Sequencer in front of the exp-Golomb decoder. Buffers bitstream words,
//   accepts "decode N elements of type SEL" commands, hands the decoder an
//   MSB-aligned window per element, drops the reported codeword length and
//   returns each decoded value on a valid/ready port.
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   word_data/valid/ready        bitstream word input (first bit at MSB)
//   cmd_sel/count/valid/ready    command input (sel: ue/se/te/reserved)
//   dec_window_o, dec_sel_o      window and element type to the decoder
//   dec_start_o                  one-cycle decode request
//   dec_value/len/done_i         decoder result
//   sym_data/valid/ready         decoded element output
//   bits_avail_o                 buffer fill, 0..32
//   busy_o                       sequencer not idle
//   err_o                        sticky protocol error (cleared by reset only)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a command
// WAIT_BITS | element pending, waiting for a full window of bits
// START     | pulse dec_start_o
// WAIT_DEC  | waiting for dec_done_i, capture value/len
// CONSUME   | shift consumed bits out, count element
// EMIT      | offer decoded value until the sink takes it
// ERR       | protocol error, everything stalled until reset
// ---------------------------------------------------------------------------
module egd_stream_ctrl
    import egd_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int BUF_W  = DEF_BUF_W,
    parameter int VAL_W  = DEF_VAL_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] word_data_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    input  logic [1:0]        cmd_sel_i,
    input  logic [CNT_W-1:0]  cmd_count_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    output logic [WORD_W-1:0] dec_window_o,
    output logic [1:0]        dec_sel_o,
    output logic              dec_start_o,
    input  logic [VAL_W-1:0]  dec_value_i,
    input  logic [LEN_W-1:0]  dec_len_i,
    input  logic              dec_done_i,
    output logic [VAL_W-1:0]  sym_data_o,
    output logic              sym_valid_o,
    input  logic              sym_ready_i,
    output logic [5:0]        bits_avail_o,
    output logic              busy_o,
    output logic              err_o
);

    egd_state_e        state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [VAL_W-1:0]  value_q, value_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic [FILL_W-1:0] fill;
    logic              buf_load;
    logic              buf_consume;

    egd_bit_buffer #(
        .WORD_W (WORD_W),
        .BUF_W  (BUF_W),
        .LEN_W  (LEN_W)
    ) u_bit_buffer (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_i        (buf_load),
        .load_word_i   (word_data_i),
        .consume_i     (buf_consume),
        .consume_len_i (len_q),
        .window_o      (dec_window_o),
        .fill_o        (fill)
    );

    // Blocking words during CONSUME keeps load and shift mutually exclusive.
    assign word_ready_o = (fill <= FILL_W'(BUF_W - WORD_W))
                          && (state_q != CONSUME) && (state_q != ERR);
    assign buf_load     = word_valid_i && word_ready_o;
    assign buf_consume  = (state_q == CONSUME);

    assign dec_sel_o    = sel_q;
    assign sym_data_o   = value_q;
    assign bits_avail_o = 6'(fill);
    assign busy_o       = (state_q != IDLE);
    assign err_o        = (state_q == ERR);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        remaining_d = remaining_q;
        value_d     = value_q;
        len_d       = len_q;
        cmd_ready_o = 1'b0;
        dec_start_o = 1'b0;
        sym_valid_o = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    sel_d       = cmd_sel_i;
                    remaining_d = cmd_count_i;
                    if (cmd_sel_i == SEL_RSVD) begin
                        state_d = ERR;
                    end else if (cmd_count_i != '0) begin
                        state_d = WAIT_BITS;
                    end
                end
            end
            WAIT_BITS: begin
                if (fill >= FILL_W'(WORD_W)) begin
                    state_d = START;
                end
            end
            START: begin
                dec_start_o = 1'b1;
                state_d     = WAIT_DEC;
            end
            WAIT_DEC: begin
                if (dec_done_i) begin
                    value_d = dec_value_i;
                    len_d   = dec_len_i;
                    // A zero or over-window length would desynchronise the stream.
                    if ((dec_len_i == '0) || (dec_len_i > LEN_W'(WORD_W))) begin
                        state_d = ERR;
                    end else begin
                        state_d = CONSUME;
                    end
                end
            end
            CONSUME: begin
                remaining_d = remaining_q - CNT_W'(1);
                state_d     = EMIT;
            end
            EMIT: begin
                sym_valid_o = 1'b1;
                if (sym_ready_i) begin
                    state_d = (remaining_q == '0) ? IDLE : WAIT_BITS;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            remaining_q <= '0;
            value_q     <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            remaining_q <= remaining_d;
            value_q     <= value_d;
            len_q       <= len_d;
        end
    end

endmodule

// File: tb/tb_egd_stream_ctrl.sv
module tb_egd_stream_ctrl;
    import egd_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [15:0] word_data_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic [1:0]  cmd_sel_i;
    logic [7:0]  cmd_count_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [15:0] dec_window_o;
    logic [1:0]  dec_sel_o;
    logic        dec_start_o;
    logic [7:0]  dec_value_i;
    logic [4:0]  dec_len_i;
    logic        dec_done_i;
    logic [7:0]  sym_data_o;
    logic        sym_valid_o;
    logic        sym_ready_i;
    logic [5:0]  bits_avail_o;
    logic        busy_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the not-yet-consumed bitstream as a plain bit queue,
    // oldest bit first, plus the values the sink should see in order.
    bit         mq[$];
    logic [7:0] exp_syms[$];
    logic [1:0] exp_sel;

    egd_stream_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .word_data_i  (word_data_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .cmd_sel_i    (cmd_sel_i),
        .cmd_count_i  (cmd_count_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .dec_window_o (dec_window_o),
        .dec_sel_o    (dec_sel_o),
        .dec_start_o  (dec_start_o),
        .dec_value_i  (dec_value_i),
        .dec_len_i    (dec_len_i),
        .dec_done_i   (dec_done_i),
        .sym_data_o   (sym_data_o),
        .sym_valid_o  (sym_valid_o),
        .sym_ready_i  (sym_ready_i),
        .bits_avail_o (bits_avail_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    function automatic logic [15:0] model_window();
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = (i < mq.size()) ? mq[i] : 1'b0;
        return w;
    endfunction

    task automatic do_reset();
        reset_n      = 1'b0;
        word_valid_i = 1'b0;
        word_data_i  = '0;
        cmd_valid_i  = 1'b0;
        cmd_sel_i    = '0;
        cmd_count_i  = '0;
        dec_done_i   = 1'b0;
        dec_len_i    = '0;
        dec_value_i  = '0;
        sym_ready_i  = 1'b0;
        tick();
        reset_n = 1'b1;
        mq.delete();
        exp_syms.delete();
        exp_sel = SEL_UE;
    endtask

    task automatic push_word(input logic [15:0] w);
        int n = 0;
        word_data_i  = w;
        word_valid_i = 1'b1;
        while (!word_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (!word_ready_o) begin
            word_valid_i = 1'b0;
            timeout("word_ready");
            return;
        end
        tick();
        word_valid_i = 1'b0;
        for (int i = 15; i >= 0; i--) mq.push_back(w[i]);
    endtask

    task automatic send_cmd(input logic [1:0] sel, input logic [7:0] cnt);
        int n = 0;
        cmd_sel_i   = sel;
        cmd_count_i = cnt;
        cmd_valid_i = 1'b1;
        while (!cmd_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready_o) begin
            cmd_valid_i = 1'b0;
            timeout("cmd_ready");
            return;
        end
        tick();
        cmd_valid_i = 1'b0;
        exp_sel     = sel;
    endtask

    // Returns with the DUT in WAIT_DEC (one cycle after the start pulse).
    task automatic wait_start();
        int n = 0;
        while (!dec_start_o && n < 100) begin
            tick();
            n++;
        end
        if (!dec_start_o) begin
            timeout("dec_start");
            return;
        end
        chk("dec_window", dec_window_o, model_window());
        chk("dec_sel", dec_sel_o, exp_sel);
        tick();
        chk("dec_start_one_cycle", dec_start_o, 0);
    endtask

    task automatic give_done(input logic [4:0] len, input logic [7:0] val, input int delay);
        repeat (delay) tick();
        dec_len_i   = len;
        dec_value_i = val;
        dec_done_i  = 1'b1;
        tick();
        dec_done_i  = 1'b0;
        if (len >= 5'd1 && len <= 5'd16) begin
            repeat (len) void'(mq.pop_front());
            exp_syms.push_back(val);
        end
    endtask

    task automatic wait_sym();
        int n = 0;
        logic [7:0] e;
        while (!sym_valid_o && n < 100) begin
            tick();
            n++;
        end
        if (!sym_valid_o) begin
            timeout("sym_valid");
            return;
        end
        e = (exp_syms.size() > 0) ? exp_syms.pop_front() : 8'h00;
        chk("sym_data", sym_data_o, e);
        chk("bits_after_consume", bits_avail_o, mq.size());
    endtask

    task automatic accept_sym(input int delay);
        repeat (delay) tick();
        sym_ready_i = 1'b1;
        tick();
        sym_ready_i = 1'b0;
    endtask

    typedef struct {
        logic [15:0] word;
        logic [1:0]  sel;
        logic [4:0]  len;
        logic [7:0]  val;
        bit          exp_err;
        logic [5:0]  exp_fill;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [1:0] rsel;
        int         rcnt;
        logic [4:0] rlen;
        logic [7:0] rval;

        vecs[0] = '{16'hA000, SEL_UE, 5'd1,  8'h00, 1'b0, 6'd15};
        vecs[1] = '{16'h1234, SEL_SE, 5'd16, 8'h7F, 1'b0, 6'd0};
        vecs[2] = '{16'hFFFF, SEL_TE, 5'd5,  8'h3C, 1'b0, 6'd11};
        vecs[3] = '{16'h0001, SEL_UE, 5'd0,  8'h12, 1'b1, 6'd16};
        vecs[4] = '{16'h0800, SEL_SE, 5'd17, 8'h34, 1'b1, 6'd16};
        vecs[5] = '{16'h5555, SEL_UE, 5'd9,  8'hA5, 1'b0, 6'd7};

        do_reset();
        chk("rst_word_ready", word_ready_o, 1);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_bits", bits_avail_o, 0);
        chk("rst_sym_valid", sym_valid_o, 0);

        // Single-element vectors, including illegal decoder lengths.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            push_word(vecs[v].word);
            chk("vec_fill_after_push", bits_avail_o, 16);
            send_cmd(vecs[v].sel, 8'd1);
            wait_start();
            chk("vec_window", dec_window_o, vecs[v].word);
            give_done(vecs[v].len, vecs[v].val, 0);
            if (vecs[v].exp_err) begin
                chk("vec_err", err_o, 1);
                chk("vec_err_word_ready", word_ready_o, 0);
                chk("vec_err_cmd_ready", cmd_ready_o, 0);
                chk("vec_err_bits", bits_avail_o, vecs[v].exp_fill);
                repeat (3) tick();
                chk("vec_err_sticky", err_o, 1);
                chk("vec_err_no_sym", sym_valid_o, 0);
                do_reset();
                chk("vec_err_cleared", err_o, 0);
                chk("vec_err_cleared_ready", cmd_ready_o, 1);
            end else begin
                wait_sym();
                chk("vec_sym", sym_data_o, vecs[v].val);
                chk("vec_fill", bits_avail_o, vecs[v].exp_fill);
                accept_sym(0);
                chk("vec_idle", busy_o, 0);
            end
        end

        // Three elements over two words, stalling for a third word.
        do_reset();
        push_word(16'hB3C5);
        push_word(16'h9E17);
        send_cmd(SEL_SE, 8'd3);
        wait_start();
        give_done(5'd9, 8'h11, 1);
        wait_sym();
        accept_sym(0);
        wait_start();
        give_done(5'd15, 8'h22, 0);
        wait_sym();
        chk("stall_fill8", bits_avail_o, 8);
        accept_sym(0);
        for (int i = 0; i < 6; i++) begin
            chk("stall_no_start", dec_start_o, 0);
            chk("stall_busy", busy_o, 1);
            tick();
        end
        chk("stall_bits", bits_avail_o, 8);
        push_word(16'h4D2B);
        wait_start();
        give_done(5'd5, 8'h33, 2);
        wait_sym();
        accept_sym(1);
        chk("three_done_idle", busy_o, 0);

        // Sink back-pressure in EMIT.
        send_cmd(SEL_TE, 8'd2);
        wait_start();
        give_done(5'd3, 8'h6A, 0);
        wait_sym();
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", sym_valid_o, 1);
            chk("hold_data", sym_data_o, 8'h6A);
            chk("hold_no_start", dec_start_o, 0);
            tick();
        end
        accept_sym(0);
        wait_start();
        give_done(5'd16, 8'h9B, 0);
        wait_sym();
        accept_sym(0);
        chk("hold_done_idle", busy_o, 0);

        // Word-ready threshold around fill 16 and load position.
        do_reset();
        push_word(16'hC0DE);
        push_word(16'h1357);
        chk("full_word_ready", word_ready_o, 0);
        send_cmd(SEL_UE, 8'd2);
        wait_start();
        give_done(5'd12, 8'h44, 0);
        wait_sym();
        chk("fill20_word_ready", word_ready_o, 0);
        accept_sym(0);
        wait_start();
        give_done(5'd5, 8'h55, 0);
        chk("consume_word_ready", word_ready_o, 0);
        wait_sym();
        chk("fill15_bits", bits_avail_o, 15);
        chk("fill15_word_ready", word_ready_o, 1);
        push_word(16'hF00F);
        chk("fill31_bits", bits_avail_o, 31);
        accept_sym(0);
        send_cmd(SEL_TE, 8'd1);
        wait_start();
        give_done(5'd16, 8'hC3, 0);
        wait_sym();
        accept_sym(0);

        // Reserved sel, zero count, reset while waiting on the decoder.
        do_reset();
        send_cmd(SEL_RSVD, 8'd1);
        chk("rsvd_err", err_o, 1);
        chk("rsvd_cmd_ready", cmd_ready_o, 0);
        do_reset();
        push_word(16'h8000);
        send_cmd(SEL_SE, 8'd0);
        for (int i = 0; i < 5; i++) begin
            chk("cnt0_idle", busy_o, 0);
            chk("cnt0_no_start", dec_start_o, 0);
            chk("cnt0_no_sym", sym_valid_o, 0);
            tick();
        end
        send_cmd(SEL_TE, 8'd1);
        wait_start();
        reset_n = 1'b0;
        tick();
        chk("wdec_rst_word_ready", word_ready_o, 1);
        chk("wdec_rst_cmd_ready", cmd_ready_o, 1);
        chk("wdec_rst_busy", busy_o, 0);
        chk("wdec_rst_err", err_o, 0);
        chk("wdec_rst_bits", bits_avail_o, 0);
        chk("wdec_rst_window", dec_window_o, 0);
        chk("wdec_rst_sel", dec_sel_o, 0);
        chk("wdec_rst_start", dec_start_o, 0);
        chk("wdec_rst_sym_valid", sym_valid_o, 0);
        chk("wdec_rst_sym_data", sym_data_o, 0);
        reset_n = 1'b1;
        mq.delete();
        exp_syms.delete();

        // Randomized commands against the bit-queue model.
        do_reset();
        for (int c = 0; c < 25; c++) begin
            rsel = 2'($urandom_range(0, 2));
            rcnt = $urandom_range(1, 4);
            while (mq.size() < 16) push_word(16'($urandom));
            if (mq.size() <= 16 && $urandom_range(0, 1) == 1) push_word(16'($urandom));
            send_cmd(rsel, 8'(rcnt));
            for (int e = 0; e < rcnt; e++) begin
                wait_start();
                rlen = 5'($urandom_range(1, 16));
                rval = 8'($urandom);
                give_done(rlen, rval, $urandom_range(0, 3));
                wait_sym();
                if (e < rcnt - 1) begin
                    while (mq.size() < 16) push_word(16'($urandom));
                    if (mq.size() <= 16 && $urandom_range(0, 1) == 1) push_word(16'($urandom));
                end
                accept_sym($urandom_range(0, 3));
            end
            chk("rand_cmd_idle", busy_o, 0);
            chk("rand_bits", bits_avail_o, mq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
